riscv_perf_counter_unit: RTL and testbench
==========================================

// Module: riscv_perf_counter_unit
// PURPOSE
//  Generalised hardware performance counter unit: N_CNT counters of CNT_WIDTH bits.
//  Each counter has its own event selector over an N_EVENTS-wide event bus.
//  Supports saturate/wrap modes, sticky overflow flags and a counter overflow interrupt.
//  Sits beside the CSR block; decodes its own CSR range and returns csr_hit_o for the core's CSR read mux.
// PARAMETERS
//  N_CNT      4   number of counters, 1..16
//  CNT_WIDTH  64  counter width, 32..64
//  N_EVENTS   16  width of events_i, 2..32
//  EVT_SEL_W  $clog2(N_EVENTS)  event selector width (derived, do not override)
// PORTS
//  clk          in   1          core clock
//  rst_n        in   1          asynchronous active-low reset
//  csr_access_i in   1          CSR instruction in flight; no access when low
//  csr_addr_i   in   12         CSR address
//  csr_wdata_i  in   32         CSR write operand
//  csr_op_i     in   2          CSR_OP_NONE/WRITE/SET/CLEAR (riscv_defines)
//  csr_rdata_o  out  32         read data, combinational, 0 when no hit
//  csr_hit_o    out  1          address decoded by this unit
//  events_i     in   N_EVENTS   one-cycle event pulses; integrator ties bit 0 to 1 (cycles)
//  cnt_irq_o    out  1          counter overflow interrupt, level
// BEHAVIOUR
//  CSR map (i < N_CNT; other addresses in the range miss):
//    0x780+i CNT_LO[i] = cnt[i][31:0]
//    0x790+i CNT_HI[i] = cnt[i][CNT_WIDTH-1:32], zero-extended; reads 0 and ignores writes if CNT_WIDTH==32
//    0x7A0+i EVTSEL[i] [EVT_SEL_W-1:0]
//    0x7C8 MODE: b0 global enable, b1 saturate, b2 overflow irq enable
//    0x7C9 OVF: bit i = sticky overflow of counter i
//  Hit requires csr_access_i=1. Write data = WRITE: wdata; SET: old|wdata; CLEAR: old&~wdata.
//    NONE, or csr_access_i=0: no write. Unimplemented bits read 0.
//  Writes take effect at the next clk edge; a read in the same cycle returns the old value.
//  Event path:
//    inc_d[i] = MODE.b0 & (EVTSEL[i] < N_EVENTS) & events_i[EVTSEL[i]], registered into inc_q[i].
//    inc_q[i]=1 updates cnt[i] on the following edge.
//    Event at cycle t is visible on read at cycle t+2.
//  Increment when inc_q[i]=1:
//    cnt != all-ones: cnt+1.
//    cnt == all-ones, MODE.b1=1: hold; OVF unchanged.
//    cnt == all-ones, MODE.b1=0: wrap to 0 and set OVF[i].
//  CSR write to CNT_LO/CNT_HI[i] in the same cycle as an increment of i:
//    write wins; the increment is lost; only the addressed half changes.
//  OVF: hardware set has priority over a software CLEAR of the same bit in the same cycle.
//  cnt_irq_o = MODE.b2 & |OVF_q. Registered state only, no combinational path from inputs.
//  EVTSEL value >= N_EVENTS: stored as written, masked to EVT_SEL_W; the counter never increments.
//  Clearing MODE.b0 stops counting 1 cycle later: events already in inc_q still count.
//  Reset values:
//    cnt=0, EVTSEL=0, MODE=3'b001, OVF=0, inc_q=0, cnt_irq_o=0, csr_hit_o=0, csr_rdata_o=0.
//    Reset mid-count clears everything immediately; no partial increment survives.
// TESTING
//  Reset, events_i[0]=1 constant, EVTSEL[0]=0
//    -> CNT_LO[0] read at cycle k after reset release = k-2 (k>=2); cnt_irq_o=0.
//  Write CNT_LO[1]=0xFFFFFFFF and CNT_HI[1]=0xFFFFFFFF (64b), MODE=3'b101, one event on EVTSEL[1]
//    -> cnt[1]=0, OVF=0x2, cnt_irq_o=1 two cycles after the pulse.
//  Same setup with MODE=3'b111
//    -> cnt[1] holds all-ones, OVF=0, cnt_irq_o=0.
//  CSR WRITE CNT_LO[0]=0x10 in a cycle where inc_q[0]=1
//    -> next read 0x10, not 0x11.
//  OVF CLEAR of bit 2 in the same cycle counter 2 wraps
//    -> OVF[2]=1. SET 0x1 to MODE when MODE=0 -> MODE=3'b001.
//    -> CLEAR 0x1 -> MODE=0; counting stops after 1 cycle.
//  EVTSEL[3]=N_EVENTS+1 with all events high
//    -> cnt[3] stays 0. Read 0x780+N_CNT -> csr_hit_o=0, rdata=0.

Source files
------------

// File: rtl/riscv_perf_counter_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_perf_counter_unit
// Description : Hardware performance counters with per-counter event select,
//               wrap/saturate modes, sticky overflow flags and overflow IRQ.
// Revision    : 1.0
// ============================================================================

module riscv_perf_counter_unit #(
  parameter int N_CNT     = 4,
  parameter int CNT_WIDTH = 64,
  parameter int N_EVENTS  = 16,
  parameter int EVT_SEL_W = $clog2(N_EVENTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                csr_access_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  input  logic [1:0]          csr_op_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_hit_o,
  input  logic [N_EVENTS-1:0] events_i,
  output logic                cnt_irq_o
);

  localparam logic [1:0] CSR_OP_NONE  = 2'd0;
  localparam logic [1:0] CSR_OP_SET   = 2'd2;
  localparam logic [1:0] CSR_OP_CLEAR = 2'd3;

  localparam logic [11:0] ADDR_MODE = 12'h7C8;
  localparam logic [11:0] ADDR_OVF  = 12'h7C9;

  localparam int                   EVT_PAD_W = 1 << EVT_SEL_W;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam bit                   HAS_HI    = (CNT_WIDTH > 32);

  logic [2:0]           mode_q, mode_d;
  logic [N_CNT-1:0]     ovf_q, ovf_d;
  logic [N_CNT-1:0]     ovf_set;
  logic [N_CNT-1:0]     cnt_hit;
  logic [31:0]          rd_part [N_CNT];

  logic                 sel_mode, sel_ovf;
  logic                 wr_en;
  logic [31:0]          old_val;
  logic [31:0]          wval;
  logic [EVT_PAD_W-1:0] evt_pad;

  // Selectors beyond N_EVENTS land on zero padding, so they never count.
  assign evt_pad = EVT_PAD_W'(events_i);

  assign sel_mode  = csr_access_i && (csr_addr_i == ADDR_MODE);
  assign sel_ovf   = csr_access_i && (csr_addr_i == ADDR_OVF);
  assign wr_en     = csr_access_i && (csr_op_i != CSR_OP_NONE);
  assign csr_hit_o = (|cnt_hit) | sel_mode | sel_ovf;

  always_comb begin
    old_val = '0;
    for (int i = 0; i < N_CNT; i++) begin
      old_val = old_val | rd_part[i];
    end
    if (sel_mode) old_val = old_val | {29'd0, mode_q};
    if (sel_ovf)  old_val = old_val | 32'(ovf_q);
  end

  assign csr_rdata_o = old_val;

  always_comb begin
    case (csr_op_i)
      CSR_OP_SET:   wval = old_val | csr_wdata_i;
      CSR_OP_CLEAR: wval = old_val & ~csr_wdata_i;
      default:      wval = csr_wdata_i;
    endcase
  end

  for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
    localparam logic [11:0] ADDR_LO  = 12'(32'h780 + gi);
    localparam logic [11:0] ADDR_HI  = 12'(32'h790 + gi);
    localparam logic [11:0] ADDR_EVT = 12'(32'h7A0 + gi);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [EVT_SEL_W-1:0] evtsel_q, evtsel_d;
    logic                 inc_q, inc_d;
    logic                 wrap;
    logic                 hit_lo, hit_hi, hit_evt;
    logic [63:0]          cnt_ext;
    logic [63:0]          hi_merge;

    assign hit_lo   = csr_access_i && (csr_addr_i == ADDR_LO);
    assign hit_hi   = csr_access_i && (csr_addr_i == ADDR_HI);
    assign hit_evt  = csr_access_i && (csr_addr_i == ADDR_EVT);
    assign cnt_ext  = 64'(cnt_q);
    assign hi_merge = {wval, cnt_ext[31:0]};

    assign inc_d    = mode_q[0] & evt_pad[evtsel_q];
    assign evtsel_d = (wr_en && hit_evt) ? wval[EVT_SEL_W-1:0] : evtsel_q;

    // A CSR write to either half overrides a concurrent increment.
    always_comb begin
      cnt_d = cnt_q;
      wrap  = 1'b0;
      if (wr_en && hit_lo) begin
        cnt_d = CNT_WIDTH'({cnt_ext[63:32], wval});
      end else if (wr_en && hit_hi && HAS_HI) begin
        cnt_d = hi_merge[CNT_WIDTH-1:0];
      end else if (inc_q) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (!mode_q[1]) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        evtsel_q <= '0;
        inc_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        evtsel_q <= evtsel_d;
        inc_q    <= inc_d;
      end
    end

    assign ovf_set[gi] = wrap;
    assign cnt_hit[gi] = hit_lo | hit_hi | hit_evt;
    assign rd_part[gi] = ({32{hit_lo}}  & cnt_ext[31:0])
                       | ({32{hit_hi}}  & cnt_ext[63:32])
                       | ({32{hit_evt}} & 32'(evtsel_q));
  end

  assign mode_d = (wr_en && sel_mode) ? wval[2:0] : mode_q;
  // Hardware overflow set beats a same-cycle software clear.
  assign ovf_d  = ((wr_en && sel_ovf) ? wval[N_CNT-1:0] : ovf_q) | ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 3'b001;
      ovf_q  <= '0;
    end else begin
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_irq_o = mode_q[2] & (|ovf_q);

endmodule

`default_nettype wire

// File: tb/tb_riscv_perf_counter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_perf_counter_unit
// Description : Directed plus randomized checks of the perf counter unit
//               against a behavioural model of the CSR-visible state.
// Revision    : 1.0
// ============================================================================

module tb_riscv_perf_counter_unit;

  localparam int N_CNT     = 4;
  localparam int CNT_WIDTH = 64;
  localparam int N_EVENTS  = 12;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                csr_access;
  logic [11:0]         csr_addr;
  logic [31:0]         csr_wdata;
  logic [1:0]          csr_op;
  logic [31:0]         csr_rdata;
  logic                csr_hit;
  logic [N_EVENTS-1:0] events;
  logic                cnt_irq;

  riscv_perf_counter_unit #(
    .N_CNT    (N_CNT),
    .CNT_WIDTH(CNT_WIDTH),
    .N_EVENTS (N_EVENTS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_access_i(csr_access),
    .csr_addr_i  (csr_addr),
    .csr_wdata_i (csr_wdata),
    .csr_op_i    (csr_op),
    .csr_rdata_o (csr_rdata),
    .csr_hit_o   (csr_hit),
    .events_i    (events),
    .cnt_irq_o   (cnt_irq)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Architectural state as seen through the CSR interface.
  bit [63:0]          m_cnt  [N_CNT];
  int                 m_sel  [N_CNT];
  bit                 m_pend [N_CNT];
  bit [2:0]           m_mode;
  bit [N_CNT-1:0]     m_ovf;

  logic [N_EVENTS-1:0] ev_bg;
  logic [31:0]         r_last;
  logic                r_irq;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_CNT; i++) begin
      m_cnt[i]  = '0;
      m_sel[i]  = 0;
      m_pend[i] = 1'b0;
    end
    m_mode = 3'b001;
    m_ovf  = '0;
  endfunction

  function automatic void model_read(input bit acc, input logic [11:0] a,
                                     output bit hit, output bit [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (acc) begin
      for (int i = 0; i < N_CNT; i++) begin
        if (int'(a) == 'h780 + i) begin hit = 1'b1; d = m_cnt[i][31:0];  end
        if (int'(a) == 'h790 + i) begin hit = 1'b1; d = m_cnt[i][63:32]; end
        if (int'(a) == 'h7A0 + i) begin hit = 1'b1; d = 32'(m_sel[i]);   end
      end
      if (a == 12'h7C8) begin hit = 1'b1; d = {29'd0, m_mode}; end
      if (a == 12'h7C9) begin hit = 1'b1; d = 32'(m_ovf);      end
    end
  endfunction

  // One clock edge: counters see the event sampled in the previous cycle.
  function automatic void model_edge(input bit acc, input logic [11:0] a, input logic [1:0] op,
                                     input logic [31:0] wd, input logic [N_EVENTS-1:0] ev);
    bit             hit, we;
    bit [31:0]      old, nv;
    bit             nxt_pend [N_CNT];
    bit [N_CNT-1:0] hw;
    model_read(acc, a, hit, old);
    case (op)
      OP_SET:   nv = old | wd;
      OP_CLEAR: nv = old & ~wd;
      default:  nv = wd;
    endcase
    we = acc && hit && (op != OP_NONE);
    hw = '0;
    for (int i = 0; i < N_CNT; i++) begin
      nxt_pend[i] = 1'b0;
      if (m_mode[0] && m_sel[i] < N_EVENTS) nxt_pend[i] = ev[m_sel[i]];
      if (we && int'(a) == 'h780 + i)      m_cnt[i] = {m_cnt[i][63:32], nv};
      else if (we && int'(a) == 'h790 + i) m_cnt[i] = {nv, m_cnt[i][31:0]};
      else if (m_pend[i]) begin
        if (m_cnt[i] != 64'hFFFF_FFFF_FFFF_FFFF) m_cnt[i] = m_cnt[i] + 64'd1;
        else if (!m_mode[1]) begin
          m_cnt[i] = '0;
          hw[i]    = 1'b1;
        end
      end
      if (we && int'(a) == 'h7A0 + i) m_sel[i] = int'(nv & 32'hF);
    end
    if (we && a == 12'h7C9) m_ovf = nv[N_CNT-1:0];
    m_ovf = m_ovf | hw;
    if (we && a == 12'h7C8) m_mode = nv[2:0];
    for (int i = 0; i < N_CNT; i++) m_pend[i] = nxt_pend[i];
  endfunction

  task automatic step(input bit acc, input logic [11:0] a, input logic [1:0] op,
                      input logic [31:0] wd, input logic [N_EVENTS-1:0] ev);
    bit        ehit;
    bit [31:0] edata;
    csr_access = acc;
    csr_addr   = a;
    csr_op     = op;
    csr_wdata  = wd;
    events     = ev;
    @(negedge clk);
    model_read(acc, a, ehit, edata);
    r_last = csr_rdata;
    r_irq  = cnt_irq;
    chk("hit",   csr_hit,   ehit);
    chk("rdata", csr_rdata, edata);
    chk("irq",   cnt_irq,   m_mode[2] && (m_ovf != 0));
    @(posedge clk);
    model_edge(acc, a, op, wd, ev);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    step(1'b1, a, OP_WRITE, v, ev_bg);
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, a, OP_NONE, 32'd0, ev_bg);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] addr_tab [18];
    addr_tab = '{12'h780, 12'h781, 12'h782, 12'h783, 12'h784, 12'h790, 12'h791,
                 12'h792, 12'h793, 12'h794, 12'h7A0, 12'h7A1, 12'h7A2, 12'h7A3,
                 12'h7C8, 12'h7C9, 12'h7CA, 12'h000};

    // Reset with the cycle event tied high.
    rst_n = 1'b0; csr_access = 1'b0; csr_addr = '0; csr_op = OP_NONE; csr_wdata = '0;
    ev_bg = 12'h001; events = ev_bg;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_irq",   cnt_irq,   1'b0);
    chk("rst_hit",   csr_hit,   1'b0);
    chk("rst_rdata", csr_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cycle k after release reads k-2.
    for (int k = 1; k <= 6; k++) begin
      rd(12'h780);
      if (k >= 2) chk("cycle_count", r_last, 32'(k - 2));
      chk("cycle_irq", r_irq, 1'b0);
    end

    // Wrap of counter 1 with overflow interrupt enabled.
    wr(12'h7A1, 32'd5);
    rd(12'h781);
    wr(12'h781, 32'hFFFF_FFFF);
    wr(12'h791, 32'hFFFF_FFFF);
    wr(12'h7C8, 32'h5);
    step(1'b1, 12'h7C9, OP_NONE, 32'd0, ev_bg | 12'h020);
    rd(12'h781);
    chk("wrap_irq_t1", r_irq, 1'b0);
    rd(12'h7C9);
    chk("wrap_ovf", r_last, 32'h2);
    chk("wrap_irq_t2", r_irq, 1'b1);
    rd(12'h781);
    chk("wrap_lo", r_last, 32'd0);
    rd(12'h791);
    chk("wrap_hi", r_last, 32'd0);
    step(1'b1, 12'h7C9, OP_CLEAR, 32'h2, ev_bg);
    rd(12'h7C9);
    chk("ovf_cleared", r_last, 32'd0);

    // Same setup in saturate mode.
    wr(12'h7C8, 32'h7);
    wr(12'h781, 32'hFFFF_FFFF);
    wr(12'h791, 32'hFFFF_FFFF);
    step(1'b1, 12'h7C9, OP_NONE, 32'd0, ev_bg | 12'h020);
    rd(12'h7C9);
    rd(12'h781);
    chk("sat_lo", r_last, 32'hFFFF_FFFF);
    rd(12'h791);
    chk("sat_hi", r_last, 32'hFFFF_FFFF);
    rd(12'h7C9);
    chk("sat_ovf", r_last, 32'd0);
    chk("sat_irq", r_irq, 1'b0);

    // CSR write beats a concurrent increment.
    wr(12'h780, 32'h10);
    rd(12'h780);
    chk("wr_wins", r_last, 32'h10);
    rd(12'h780);
    chk("wr_then_inc", r_last, 32'h11);

    // Hardware overflow set beats software clear of the same bit.
    wr(12'h7C8, 32'h5);
    wr(12'h792, 32'hFFFF_FFFF);
    wr(12'h782, 32'hFFFF_FFFF);
    step(1'b1, 12'h7C9, OP_CLEAR, 32'h4, ev_bg);
    rd(12'h7C9);
    chk("ovf_prio", r_last, 32'h4);
    chk("ovf_prio_irq", r_irq, 1'b1);
    wr(12'h7C9, 32'h0);

    // MODE set/clear and counting stop.
    wr(12'h7C8, 32'h0);
    step(1'b1, 12'h7C8, OP_SET, 32'h1, ev_bg);
    rd(12'h7C8);
    chk("mode_set", r_last, 32'h1);
    step(1'b1, 12'h7C8, OP_CLEAR, 32'h1, ev_bg);
    rd(12'h7C8);
    chk("mode_clear", r_last, 32'h0);
    repeat (4) rd(12'h780);
    wr(12'h7C8, 32'h1);

    // Out-of-range selector never counts.
    ev_bg = '1;
    wr(12'h7A3, 32'(N_EVENTS + 1));
    wr(12'h783, 32'h0);
    wr(12'h793, 32'h0);
    repeat (4) begin
      rd(12'h783);
      chk("evtsel_oor_cnt", r_last, 32'd0);
    end
    rd(12'h7A3);
    chk("evtsel_stored", r_last, 32'(N_EVENTS + 1));

    // Unmapped addresses in the range.
    rd(12'h784);
    chk("miss_hit", csr_hit, 1'b0);
    chk("miss_rdata", r_last, 32'd0);
    rd(12'h7A4);
    step(1'b0, 12'h7C8, OP_WRITE, 32'h0, ev_bg);
    rd(12'h7C8);
    chk("noaccess_nowrite", r_last, 32'h1);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      bit          acc;
      logic [11:0] a;
      logic [1:0]  op;
      logic [31:0] wd;
      acc = ($urandom_range(0, 3) != 0);
      a   = addr_tab[$urandom_range(0, 17)];
      op  = 2'($urandom_range(0, 3));
      wd  = $urandom;
      if ($urandom_range(0, 2) == 0) wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if (a == 12'h7C8 && $urandom_range(0, 3) != 0) wd = wd | 32'h1;
      if (a == 12'h7C9 && op == OP_SET) op = OP_CLEAR;
      step(acc, a, op, wd, 12'($urandom) | 12'h001);
    end

    // Asynchronous reset mid-count.
    #2;
    rst_n = 1'b0; csr_access = 1'b1; csr_addr = 12'h780; csr_op = OP_NONE;
    #1;
    chk("midrst_lo",  csr_rdata, 32'd0);
    chk("midrst_irq", cnt_irq,   1'b0);
    csr_addr = 12'h7C8;
    #1;
    chk("midrst_mode", csr_rdata, 32'h1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ev_bg = 12'h001;
    repeat (5) rd(12'h780);
    rd(12'h781);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
